// File: rtl/oflow_core_reg_scheduler_if.sv
// oflow_core_reg_scheduler_if: registration write-port arbitration bus
// start_reg/active_mask: set start and valid-PE mask; req_i/wr_ack: per-PE requests and buffer accept
// gnt_o/gnt_idx: one-hot grant and its index; busy/served_cnt/done_registration: set status
interface oflow_core_reg_scheduler_if #(
  parameter int PE_NUM = 24,
  parameter int IDX_W  = $clog2(PE_NUM)
);
  logic              start_reg;
  logic [PE_NUM-1:0] active_mask;
  logic [PE_NUM-1:0] req_i;
  logic              wr_ack;
  logic [PE_NUM-1:0] gnt_o;
  logic [IDX_W-1:0]  gnt_idx;
  logic              busy;
  logic [IDX_W:0]    served_cnt;
  logic              done_registration;
  modport master (
    output start_reg, active_mask, req_i, wr_ack,
    input  gnt_o, gnt_idx, busy, served_cnt, done_registration
  );
  modport slave (
    input  start_reg, active_mask, req_i, wr_ack,
    output gnt_o, gnt_idx, busy, served_cnt, done_registration
  );
endinterface

// File: rtl/oflow_core_reg_scheduler.sv
// oflow_core_reg_scheduler: round-robin scheduler granting PEs the shared registration write port
// clk: clock; reset_N: synchronous active-high reset; bus: scheduler side of the arbitration bus
module oflow_core_reg_scheduler #(
  parameter int PE_NUM = 24,
  parameter int IDX_W  = $clog2(PE_NUM)
) (
  input logic                      clk,
  input logic                      reset_N,
  oflow_core_reg_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARB, WAIT_ACK, DONE} state_t;
  localparam logic [IDX_W:0] PE_N = (IDX_W+1)'(PE_NUM);
  state_t              state_q, state_d;
  logic [PE_NUM-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic [IDX_W:0]      served_cnt_q, served_cnt_d;
  logic                done_q;
  logic [PE_NUM-1:0]   cand, gnt_oh, rot;
  logic [2*PE_NUM-1:0] dbl;
  logic [IDX_W-1:0]    off, sel;
  logic [IDX_W:0]      sum;
  // Rotate candidates so bit 0 sits at rr_ptr; the lowest set bit is then the round-robin winner.
  always_comb begin
    cand   = pending_q & bus.req_i;
    gnt_oh = {{(PE_NUM-1){1'b0}}, 1'b1} << grant_idx_q;
    dbl    = {cand, cand} >> rr_ptr_q;
    rot    = dbl[PE_NUM-1:0];
    off    = '0;
    for (int i = PE_NUM-1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
    sum = {1'b0, rr_ptr_q} + {1'b0, off};
    sel = IDX_W'(sum >= PE_N ? sum - PE_N : sum);
  end
  always_ff @(posedge clk) begin
    if (reset_N) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      grant_idx_q  <= '0;
      served_cnt_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_idx_q  <= grant_idx_d;
      served_cnt_q <= served_cnt_d;
      done_q       <= state_q == DONE;
    end
  end
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx_d  = grant_idx_q;
    served_cnt_d = served_cnt_q;
    case (state_q)
      IDLE: if (bus.start_reg) begin
        pending_d    = bus.active_mask;
        served_cnt_d = '0;
        state_d      = bus.active_mask == '0 ? DONE : ARB;
      end
      ARB: if (cand != '0) begin
        grant_idx_d = sel;
        state_d     = WAIT_ACK;
      end
      WAIT_ACK: if (bus.wr_ack) begin
        pending_d    = pending_q & ~gnt_oh;
        rr_ptr_d     = grant_idx_q == IDX_W'(PE_NUM-1) ? '0 : grant_idx_q + 1'b1;
        served_cnt_d = served_cnt_q + 1'b1;
        state_d      = (pending_q & ~gnt_oh) == '0 ? DONE : ARB;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.gnt_o             = state_q == WAIT_ACK ? gnt_oh : '0;
    bus.gnt_idx           = grant_idx_q;
    bus.busy              = state_q != IDLE;
    bus.served_cnt        = served_cnt_q;
    bus.done_registration = done_q;
  end
endmodule

// File: tb/tb_oflow_core_reg_scheduler.sv
// tb_oflow_core_reg_scheduler: directed self-checking bench for the registration scheduler
module tb_oflow_core_reg_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total = 0;
  int   order [3] = '{23, 1, 5};
  oflow_core_reg_scheduler_if #(.PE_NUM(24)) bus ();
  oflow_core_reg_scheduler #(.PE_NUM(24)) dut (.clk(clk), .reset_N(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  initial begin
    bus.start_reg   = 1'b0;
    bus.active_mask = '0;
    bus.req_i       = '0;
    bus.wr_ack      = 1'b0;
    tick();
    tick();
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_idx", bus.gnt_idx, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.served_cnt, 0);
    chk("rst_done", bus.done_registration, 0);
    rst = 1'b0;
    tick();
    // four PEs, acked the cycle they are granted
    bus.active_mask = 24'h00000F;
    bus.req_i       = '1;
    bus.wr_ack      = 1'b1;
    bus.start_reg   = 1'b1;
    tick();
    bus.start_reg = 1'b0;
    chk("t1_busy", bus.busy, 1);
    chk("t1_gnt_arb", bus.gnt_o, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_gnt", bus.gnt_o, 32'd1 << k);
      chk("t1_idx", bus.gnt_idx, k);
      tick();
      chk("t1_gap", bus.gnt_o, 0);
      chk("t1_done_early", bus.done_registration, 0);
    end
    chk("t1_cnt", bus.served_cnt, 4);
    tick();
    chk("t1_done", bus.done_registration, 1);
    chk("t1_idle", bus.busy, 0);
    tick();
    chk("t1_done_once", bus.done_registration, 0);
    chk("t1_cnt_hold", bus.served_cnt, 4);
    // empty set
    bus.wr_ack      = 1'b0;
    bus.active_mask = '0;
    bus.start_reg   = 1'b1;
    tick();
    bus.start_reg = 1'b0;
    chk("t2_done_early", bus.done_registration, 0);
    chk("t2_cnt", bus.served_cnt, 0);
    chk("t2_gnt", bus.gnt_o, 0);
    tick();
    chk("t2_done", bus.done_registration, 1);
    chk("t2_gnt2", bus.gnt_o, 0);
    tick();
    chk("t2_done_once", bus.done_registration, 0);
    // serve PE 21 alone so the pointer lands on 22
    bus.active_mask = 24'h200000;
    bus.wr_ack      = 1'b1;
    bus.start_reg   = 1'b1;
    tick();
    bus.start_reg = 1'b0;
    tick();
    chk("t3_pre_idx", bus.gnt_idx, 21);
    tick();
    tick();
    tick();
    // pending {1,5,23} from pointer 22 wraps to 23, 1, 5
    bus.active_mask = 24'h800022;
    bus.start_reg   = 1'b1;
    tick();
    bus.start_reg = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_idx", bus.gnt_idx, order[k]);
      chk("t3_gnt", bus.gnt_o, 32'd1 << order[k]);
      tick();
    end
    chk("t3_cnt", bus.served_cnt, 3);
    tick();
    chk("t3_done", bus.done_registration, 1);
    tick();
    // grant held through request drop and late ack; ack in ARB ignored
    bus.wr_ack      = 1'b0;
    bus.active_mask = 24'h001400;
    bus.req_i       = 24'h000400;
    bus.start_reg   = 1'b1;
    tick();
    bus.start_reg = 1'b0;
    tick();
    chk("t4_idx", bus.gnt_idx, 10);
    bus.req_i = '0;
    for (int k = 0; k < 4; k++) begin
      chk("t4_hold", bus.gnt_o, 32'h400);
      tick();
    end
    chk("t4_hold_last", bus.gnt_o, 32'h400);
    chk("t4_cnt_wait", bus.served_cnt, 0);
    bus.wr_ack = 1'b1;
    tick();
    chk("t4_cnt1", bus.served_cnt, 1);
    chk("t4_arb_gnt", bus.gnt_o, 0);
    tick();
    chk("t4_arb_ack_cnt", bus.served_cnt, 1);
    chk("t4_arb_ack_gnt", bus.gnt_o, 0);
    chk("t4_arb_busy", bus.busy, 1);
    bus.wr_ack = 1'b0;
    bus.req_i  = 24'h001000;
    tick();
    chk("t4_idx12", bus.gnt_idx, 12);
    chk("t4_cnt_still", bus.served_cnt, 1);
    bus.wr_ack = 1'b1;
    tick();
    chk("t4_cnt2", bus.served_cnt, 2);
    bus.wr_ack = 1'b0;
    tick();
    chk("t4_done", bus.done_registration, 1);
    tick();
    // start while busy is ignored; reset during WAIT_ACK aborts silently
    bus.active_mask = 24'h000003;
    bus.req_i       = '1;
    bus.start_reg   = 1'b1;
    tick();
    bus.start_reg = 1'b0;
    tick();
    chk("t5_idx0", bus.gnt_idx, 0);
    bus.wr_ack = 1'b1;
    tick();
    chk("t5_cnt1", bus.served_cnt, 1);
    bus.wr_ack      = 1'b0;
    bus.active_mask = 24'h00000F;
    bus.start_reg   = 1'b1;
    tick();
    bus.start_reg = 1'b0;
    chk("t5_busy_start_idx", bus.gnt_idx, 1);
    chk("t5_busy_start_cnt", bus.served_cnt, 1);
    tick();
    chk("t5_wait_gnt", bus.gnt_o, 2);
    rst           = 1'b1;
    bus.start_reg = 1'b1;
    bus.wr_ack    = 1'b1;
    tick();
    chk("t5_rst_gnt", bus.gnt_o, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_cnt", bus.served_cnt, 0);
    chk("t5_rst_idx", bus.gnt_idx, 0);
    chk("t5_rst_done", bus.done_registration, 0);
    rst           = 1'b0;
    bus.start_reg = 1'b0;
    bus.wr_ack    = 1'b0;
    tick();
    chk("t5_post_busy", bus.busy, 0);
    chk("t5_post_done", bus.done_registration, 0);
    tick();
    chk("t5_post_done2", bus.done_registration, 0);
    // only masked PE 8 may be granted
    bus.active_mask = 24'h000100;
    bus.req_i       = '1;
    bus.wr_ack      = 1'b1;
    bus.start_reg   = 1'b1;
    tick();
    bus.start_reg = 1'b0;
    tick();
    chk("t6_gnt", bus.gnt_o, 32'h100);
    chk("t6_idx", bus.gnt_idx, 8);
    tick();
    chk("t6_gnt_after", bus.gnt_o, 0);
    chk("t6_cnt", bus.served_cnt, 1);
    tick();
    chk("t6_done", bus.done_registration, 1);
    tick();
    chk("t6_idle", bus.busy, 0);
    chk("t6_done_once", bus.done_registration, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
